cdr_phase_controller: RTL

- Digital CDR loop controller. Consumes the sampler's Alexander (bang-bang) outputs Dn_1, Dn and Pn, and decides per cycle whether the sampling clock is early or late.
- Filters the decisions with a vote accumulator and steps a wrapping phase-interpolator code.
- Sequences acquisition, settling, lock detection and tracking.
- Sits between the sampler and the phase interpolator that drives data_clock/phase_clock.

---
 rtl/cdr_phase_controller.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cdr_phase_controller.sv
// cdr_phase_controller
//   Digital CDR loop controller. Takes the Alexander (bang-bang) phase
//   detector samples from the data sampler, filters the early/late votes
//   in a saturating accumulator and steps a wrapping phase-interpolator
//   code. It sequences acquisition, post-step settling, lock detection
//   and tracking.
//
//   Optional feature macro: CDR_MANUAL_OVERRIDE_EN
//     When defined, adds manual_en/manual_code. While manual_en is high,
//     the code follows manual_code and the loop is held in IDLE.
//
// Ports:
//   data_clock    in   1       controller clock (single domain)
//   Reset         in   1       synchronous, active-high reset
//   enable        in   1       loop enable
//   Dn_1          in   1       previous data sample
//   Dn            in   1       current data sample
//   Pn            in   1       edge sample between Dn_1 and Dn
//   manual_en     in   1       (macro only) manual code override
//   manual_code   in   CODE_W  (macro only) manual phase code
//   phase_code    out  CODE_W  phase interpolator code
//   phase_update  out  1       pulse in the first cycle a new code is valid
//   locked        out  1       lock indicator
//   state         out  2       IDLE=0, ACQ=1, TRACK=2, SETTLE=3
module cdr_phase_controller #(
  parameter int CODE_W       = 6,
  parameter int ACC_W        = 8,
  parameter int ACQ_THRESH   = 4,
  parameter int TRK_THRESH   = 16,
  parameter int SETTLE_CYC   = 4,
  parameter int LOCK_WIN     = 256,
  parameter int UNLOCK_STEPS = 8
) (
  input  logic              data_clock,
  input  logic              Reset,
  input  logic              enable,
  input  logic              Dn_1,
  input  logic              Dn,
  input  logic              Pn,
`ifdef CDR_MANUAL_OVERRIDE_EN
  input  logic              manual_en,
  input  logic [CODE_W-1:0] manual_code,
`endif
  output logic [CODE_W-1:0] phase_code,
  output logic              phase_update,
  output logic              locked,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int QW = $clog2(LOCK_WIN + 1);
  localparam int UW = $clog2(UNLOCK_STEPS + 1);

  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYC);
  localparam logic [QW-1:0] LOCK_CNT    = QW'(LOCK_WIN);
  localparam logic [UW-1:0] UNLOCK_CNT  = UW'(UNLOCK_STEPS);

  localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN   = -ACC_MAX;
  localparam logic signed [ACC_W:0]   ACC_MAX_W = (ACC_W + 1)'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0]   ACC_MIN_W = -ACC_MAX_W;
  localparam logic signed [ACC_W:0]   ONE_W     = (ACC_W + 1)'(1);
  localparam logic signed [ACC_W-1:0] ACQ_THR   = ACC_W'(ACQ_THRESH);
  localparam logic signed [ACC_W-1:0] TRK_THR   = ACC_W'(TRK_THRESH);

  // Registered state
  state_e                   state_q,  state_d;
  logic [CODE_W-1:0]        code_q,   code_d;
  logic                     upd_q,    upd_d;
  logic                     locked_q, locked_d;
  logic signed [ACC_W-1:0]  acc_q,    acc_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [QW-1:0]            quiet_q,  quiet_d;
  logic [UW-1:0]            same_q,   same_d;
  logic                     lastup_q, lastup_d;

  // Phase detector and vote filter
  logic                     trans, late, early;
  logic signed [ACC_W:0]    acc_ext, acc_wide;
  logic signed [ACC_W-1:0]  acc_next, thr;
  logic                     step_up, step_dn;
  logic [QW-1:0]            quiet_inc;
  logic [UW-1:0]            same_nxt;

  always_comb begin
    trans = Dn_1 ^ Dn;
    late  = trans & (Pn == Dn_1);
    early = trans & (Pn == Dn);
  end

  // Sum is formed one bit wider so saturation can be detected before
  // truncating back to ACC_W.
  always_comb begin
    acc_ext = {acc_q[ACC_W-1], acc_q};
    if (late) begin
      acc_wide = acc_ext + ONE_W;
    end else if (early) begin
      acc_wide = acc_ext - ONE_W;
    end else begin
      acc_wide = acc_ext;
    end

    if (acc_wide > ACC_MAX_W) begin
      acc_next = ACC_MAX;
    end else if (acc_wide < ACC_MIN_W) begin
      acc_next = ACC_MIN;
    end else begin
      acc_next = acc_wide[ACC_W-1:0];
    end

    thr     = (state_q == TRACK) ? TRK_THR : ACQ_THR;
    step_up = (acc_next >= thr);
    step_dn = (acc_next <= -thr);
  end

  always_comb begin
    quiet_inc = quiet_q + QW'(1);
    // A run restarts at 1 on the first step after lock or on a reversal.
    if ((same_q != '0) && (lastup_q == step_up)) begin
      same_nxt = same_q + UW'(1);
    end else begin
      same_nxt = UW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    upd_d    = 1'b0;
    locked_d = locked_q;
    acc_d    = acc_q;
    settle_d = settle_q;
    quiet_d  = quiet_q;
    same_d   = same_q;
    lastup_d = lastup_q;

`ifdef CDR_MANUAL_OVERRIDE_EN
    if (manual_en) begin
      state_d  = IDLE;
      code_d   = manual_code;
      upd_d    = (manual_code != code_q);
      locked_d = 1'b0;
      acc_d    = '0;
      settle_d = '0;
      quiet_d  = '0;
      same_d   = '0;
    end else
`endif
    if (!enable) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      acc_d    = '0;
      settle_d = '0;
      quiet_d  = '0;
      same_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQ;
        end

        ACQ, TRACK: begin
          if (step_up || step_dn) begin
            code_d   = step_up ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
            upd_d    = 1'b1;
            acc_d    = '0;
            state_d  = SETTLE;
            settle_d = SETTLE_INIT;
            lastup_d = step_up;
            if (state_q == ACQ) begin
              quiet_d = '0;
            end else if (same_nxt == UNLOCK_CNT) begin
              // Unlock: this step still settles, and SETTLE then
              // exits to ACQ because locked is already low.
              locked_d = 1'b0;
              quiet_d  = '0;
              same_d   = '0;
            end else begin
              same_d = same_nxt;
            end
          end else begin
            acc_d = acc_next;
            if (state_q == ACQ) begin
              quiet_d = quiet_inc;
              if (quiet_inc == LOCK_CNT) begin
                locked_d = 1'b1;
                state_d  = TRACK;
                acc_d    = '0;
                same_d   = '0;
                quiet_d  = '0;
              end
            end
          end
        end

        SETTLE: begin
          settle_d = settle_q - SW'(1);
          if (settle_q == SW'(1)) begin
            state_d = locked_q ? TRACK : ACQ;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge data_clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      code_q   <= '0;
      upd_q    <= 1'b0;
      locked_q <= 1'b0;
      acc_q    <= '0;
      settle_q <= '0;
      quiet_q  <= '0;
      same_q   <= '0;
      lastup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      upd_q    <= upd_d;
      locked_q <= locked_d;
      acc_q    <= acc_d;
      settle_q <= settle_d;
      quiet_q  <= quiet_d;
      same_q   <= same_d;
      lastup_q <= lastup_d;
    end
  end

  assign phase_code   = code_q;
  assign phase_update = upd_q;
  assign locked       = locked_q;
  assign state        = state_q;

endmodule
